// File: rtl/im_fetch_arbiter.sv
// rtl/im_fetch_arbiter.sv - two-requester round-robin arbiter for a 1-cycle synchronous-read instruction memory
// Responses are tagged with the owner id and delivered as a registered rvalid pulse; flush drops in-flight entries.
module im_fetch_arbiter #(
  parameter int DW = 36,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] adr0,
  input  logic          flush0,
  output logic          gnt0,
  output logic [DW-1:0] rdata0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic [AW-1:0] adr1,
  input  logic          flush1,
  output logic          gnt1,
  output logic [DW-1:0] rdata1,
  output logic          rvalid1,
  output logic [AW-1:0] pmadr,
  input  logic [DW-1:0] pmout
);

  logic          r_lp;
  logic          r_s1_v;
  logic          r_s1_id;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_m0;
  logic          w_m1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_dlv0;
  logic          w_dlv1;

  // A flushing requester is masked so it never sees a grant in its flush cycle.
  assign w_m0   = req0 & ~flush0;
  assign w_m1   = req1 & ~flush1;
  assign w_gnt0 = ~rst & w_m0 & (~w_m1 | r_lp);
  assign w_gnt1 = ~rst & w_m1 & (~w_m0 | ~r_lp);

  assign gnt0   = w_gnt0;
  assign gnt1   = w_gnt1;
  assign pmadr  = w_gnt0 ? adr0 : (w_gnt1 ? adr1 : '0);

  // Flush of the owner on the delivery edge wins over the load.
  assign w_dlv0 = r_s1_v & ~r_s1_id & ~flush0;
  assign w_dlv1 = r_s1_v &  r_s1_id & ~flush1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lp      <= 1'b1;
      r_s1_v    <= 1'b0;
      r_s1_id   <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      if (w_gnt0) begin
        r_lp <= 1'b0;
      end else if (w_gnt1) begin
        r_lp <= 1'b1;
      end
      r_s1_v    <= w_gnt0 | w_gnt1;
      r_s1_id   <= w_gnt1;
      r_rvalid0 <= w_dlv0;
      r_rvalid1 <= w_dlv1;
      if (w_dlv0) begin
        r_rdata0 <= pmout;
      end
      if (w_dlv1) begin
        r_rdata1 <= pmout;
      end
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_im_fetch_arbiter.sv
// tb/tb_im_fetch_arbiter.sv - directed self-checking bench for im_fetch_arbiter
// Memory model: 1-cycle registered read, mem[k] = 36'h100 + k.
module tb_im_fetch_arbiter;

  localparam int DW = 36;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] adr0 = '0, adr1 = '0;
  logic          flush0 = 1'b0, flush1 = 1'b0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] pmadr;
  logic [DW-1:0] pmout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) pmout <= 36'h100 + {4'b0, pmadr};

  im_fetch_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .adr0(adr0), .flush0(flush0), .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .adr1(adr1), .flush1(flush1), .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .pmadr(pmadr), .pmout(pmout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven for the new cycle.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic [AW-1:0] a0, input logic f0,
                       input logic r1, input logic [AW-1:0] a1, input logic f1);
    req0 = r0; adr0 = a0; flush0 = f0;
    req1 = r1; adr1 = a1; flush1 = f1;
    #1;
  endtask

  initial begin
    // Reset state: grants and pmadr forced low even with a request pending
    drive(1, 5, 0, 1, 9, 0);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_pmadr", pmadr, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rdata0", rdata0, 0);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    nxt(); rst = 1'b0;

    // Single fetch from requester 0
    nxt(); drive(1, 5, 0, 0, 0, 0);
    chk("t1_gnt0", gnt0, 1);
    chk("t1_gnt1", gnt1, 0);
    chk("t1_pmadr", pmadr, 5);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    chk("t1_idle_pmadr", pmadr, 0);
    chk("t1_rvalid0_early", rvalid0, 0);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    chk("t1_rvalid0", rvalid0, 1);
    chk("t1_rdata0", rdata0, 36'h105);
    chk("t1_rvalid1", rvalid1, 0);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    chk("t1_rvalid0_drop", rvalid0, 0);
    chk("t1_rdata0_hold", rdata0, 36'h105);

    // Back-to-back requester 1 fetches (lp=0 now, but req1 alone)
    nxt(); drive(0, 0, 0, 1, 3, 0);
    chk("t3_gnt1_a", gnt1, 1);
    chk("t3_gnt0_a", gnt0, 0);
    chk("t3_pmadr_a", pmadr, 3);
    nxt(); drive(0, 0, 0, 1, 4, 0);
    chk("t3_gnt1_b", gnt1, 1);
    chk("t3_gnt0_b", gnt0, 0);
    nxt(); drive(0, 0, 0, 1, 5, 0);
    chk("t3_gnt0_c", gnt0, 0);
    chk("t3_rvalid1_a", rvalid1, 1);
    chk("t3_rdata1_a", rdata1, 36'h103);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    chk("t3_rvalid1_b", rvalid1, 1);
    chk("t3_rdata1_b", rdata1, 36'h104);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    chk("t3_rvalid1_c", rvalid1, 1);
    chk("t3_rdata1_c", rdata1, 36'h105);
    chk("t3_rvalid0_c", rvalid0, 0);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    chk("t3_rvalid1_end", rvalid1, 0);

    // Continuous dual request: lp=1, so grants go 0,1,0,1
    nxt(); drive(1, 2, 0, 1, 9, 0);
    chk("t2_gnt0_1", gnt0, 1); chk("t2_gnt1_1", gnt1, 0); chk("t2_pmadr_1", pmadr, 2);
    nxt(); drive(1, 2, 0, 1, 9, 0);
    chk("t2_gnt0_2", gnt0, 0); chk("t2_gnt1_2", gnt1, 1); chk("t2_pmadr_2", pmadr, 9);
    nxt(); drive(1, 2, 0, 1, 9, 0);
    chk("t2_gnt0_3", gnt0, 1); chk("t2_gnt1_3", gnt1, 0);
    chk("t2_rv0_3", rvalid0, 1); chk("t2_rv1_3", rvalid1, 0); chk("t2_rd0_3", rdata0, 36'h102);
    nxt(); drive(1, 2, 0, 1, 9, 0);
    chk("t2_gnt0_4", gnt0, 0); chk("t2_gnt1_4", gnt1, 1);
    chk("t2_rv0_4", rvalid0, 0); chk("t2_rv1_4", rvalid1, 1); chk("t2_rd1_4", rdata1, 36'h109);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    chk("t2_rv0_5", rvalid0, 1); chk("t2_rv1_5", rvalid1, 0);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    chk("t2_rv0_6", rvalid0, 0); chk("t2_rv1_6", rvalid1, 1);
    nxt(); drive(0, 0, 0, 0, 0, 0);

    // Flush0 cancels requester 0's in-flight entry; requester 1 unaffected
    nxt(); drive(1, 7, 0, 0, 0, 0);
    chk("t4_gnt0", gnt0, 1);
    nxt(); drive(0, 0, 1, 1, 8, 0);
    chk("t4_gnt1", gnt1, 1);
    chk("t4_pmadr", pmadr, 8);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    chk("t4_rvalid0", rvalid0, 0);
    chk("t4_rdata0_kept", rdata0, 36'h102);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    chk("t4_rvalid0_b", rvalid0, 0);
    chk("t4_rvalid1", rvalid1, 1);
    chk("t4_rdata1", rdata1, 36'h108);

    // Flush1 masks requester 1 from a tie it would otherwise win (lp=0)
    nxt(); drive(1, 0, 0, 0, 0, 0);
    chk("t5_pre_gnt0", gnt0, 1);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    nxt(); drive(1, 1, 0, 1, 6, 1);
    chk("t5_gnt0", gnt0, 1);
    chk("t5_gnt1", gnt1, 0);
    chk("t5_pmadr", pmadr, 1);
    chk("t5_pre_rdata0", rdata0, 36'h100);
    nxt(); drive(1, 1, 0, 1, 6, 0);
    chk("t5_tie_gnt1", gnt1, 1);
    chk("t5_tie_gnt0", gnt0, 0);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    chk("t5_rv0", rvalid0, 1); chk("t5_rd0", rdata0, 36'h101);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    chk("t5_rv1", rvalid1, 1); chk("t5_rd1", rdata1, 36'h106);
    nxt(); drive(0, 0, 0, 0, 0, 0);

    // Reset between grant and delivery
    nxt(); drive(1, 4, 0, 0, 0, 0);
    chk("t6_gnt0", gnt0, 1);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("t6_rdata0_clr", rdata0, 0);
    chk("t6_rdata1_clr", rdata1, 0);
    chk("t6_rvalid0", rvalid0, 0);
    nxt();
    chk("t6_rvalid0_b", rvalid0, 0);
    chk("t6_rvalid1_b", rvalid1, 0);
    rst = 1'b0;
    nxt(); drive(1, 3, 0, 1, 4, 0);
    chk("t6_tie_gnt0", gnt0, 1);
    chk("t6_tie_gnt1", gnt1, 0);
    chk("t6_rvalid0_c", rvalid0, 0);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    chk("t6_rvalid0_d", rvalid0, 0);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    chk("t6_rvalid0_e", rvalid0, 1);
    chk("t6_rdata0_e", rdata0, 36'h103);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
